// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter and fetches one instruction per step
// over a req/ack handshake to instruction memory, then advances, loads or halts the PC.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INST_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_EN,
    input  logic              PC_LD_EN,
    input  logic [ADDR_W-1:0] PC_LD_ADDR,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [INST_W-1:0] IMEM_RDATA,
    output logic [INST_W-1:0] INST,
    output logic              INST_VALID,
    output logic [ADDR_W-1:0] PC,
    output logic              HALTED,
    output logic [CNT_W-1:0]  RETIRED
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (IMEM_ACK) begin
                    inst_d  = IMEM_RDATA;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Halting also retires the instruction that requested it.
                if (retired_q != '1) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                if (PC_LD_EN) begin
                    pc_d    = PC_LD_ADDR;
                    state_d = StFetch;
                end else if (PC_EN) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StFetch;
                end else begin
                    state_d = StHalt;
                end
            end
            StHalt: state_d = StHalt;
        endcase
    end

    assign IMEM_REQ   = (state_q == StFetch);
    assign IMEM_ADDR  = pc_q;
    assign INST       = inst_q;
    assign INST_VALID = (state_q == StExec);
    assign PC         = pc_q;
    assign HALTED     = (state_q == StHalt);
    assign RETIRED    = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch address/instruction pairs are queued
// when the PC decision is driven and compared when the DUT presents the fetch and its EXEC.
module tb_instr_fetch_unit;

    localparam int unsigned CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             PC_EN = 1'b0;
    logic             PC_LD_EN = 1'b0;
    logic [7:0]       PC_LD_ADDR = 8'h00;
    logic             IMEM_REQ;
    logic [7:0]       IMEM_ADDR;
    logic             IMEM_ACK = 1'b0;
    logic [7:0]       IMEM_RDATA = 8'h00;
    logic [7:0]       INST;
    logic             INST_VALID;
    logic [7:0]       PC;
    logic             HALTED;
    logic [CNT_W-1:0] RETIRED;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .INST_W  (8),
        .RESET_PC(8'h00),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_EN     (PC_EN),
        .PC_LD_EN  (PC_LD_EN),
        .PC_LD_ADDR(PC_LD_ADDR),
        .IMEM_REQ  (IMEM_REQ),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_ACK  (IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA),
        .INST      (INST),
        .INST_VALID(INST_VALID),
        .PC        (PC),
        .HALTED    (HALTED),
        .RETIRED   (RETIRED)
    );

    always #5 CLK = ~CLK;

    logic [7:0]       mem [256];
    logic [15:0]      sb_q [$];
    logic [7:0]       exp_pc;
    logic [CNT_W-1:0] exp_retired;
    logic [7:0]       last_inst;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Asserts reset between edges and checks the reset state takes effect immediately.
    task automatic apply_reset();
        #2 RST = 1'b1;
        #1;
        check_eq("rst_req", IMEM_REQ, 1'b0);
        check_eq("rst_valid", INST_VALID, 1'b0);
        check_eq("rst_halted", HALTED, 1'b0);
        check_eq("rst_pc", PC, 8'h00);
        check_eq("rst_inst", INST, 8'h00);
        check_eq("rst_retired", RETIRED, 0);
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 8'hEE;
        @(negedge CLK);
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        RST = 1'b0;
        sb_q.delete();
        exp_pc = 8'h00;
        exp_retired = '0;
        sb_q.push_back({8'h00, mem[0]});
    endtask

    task automatic do_instr(input int waits, input logic en, input logic ld, input logic [7:0] tgt);
        logic [15:0] e;
        logic        halt;
        int          n;
        n = 0;
        while (IMEM_REQ !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check_eq("req_seen", IMEM_REQ, 1'b1);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_eq("imem_addr", IMEM_ADDR, e[15:8]);
        for (int i = 0; i < waits; i++) begin
            PC_EN = 1'($urandom);
            PC_LD_EN = 1'($urandom);
            PC_LD_ADDR = 8'($urandom);
            check_eq("req_hold", IMEM_REQ, 1'b1);
            check_eq("addr_hold", IMEM_ADDR, e[15:8]);
            check_eq("no_valid_wait", INST_VALID, 1'b0);
            @(negedge CLK);
        end
        IMEM_ACK = 1'b1;
        IMEM_RDATA = mem[IMEM_ADDR];
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        IMEM_RDATA = 8'h00;
        check_eq("inst_valid", INST_VALID, 1'b1);
        check_eq("inst", INST, e[7:0]);
        last_inst = e[7:0];
        PC_EN = en;
        PC_LD_EN = ld;
        PC_LD_ADDR = tgt;
        halt = 1'b0;
        if (ld) exp_pc = tgt;
        else if (en) exp_pc = exp_pc + 8'd1;
        else halt = 1'b1;
        if (exp_retired != '1) exp_retired = exp_retired + 1'b1;
        if (!halt) sb_q.push_back({exp_pc, mem[exp_pc]});
        @(negedge CLK);
        PC_EN = 1'($urandom);
        PC_LD_EN = 1'($urandom);
        PC_LD_ADDR = 8'($urandom);
        check_eq("valid_pulse", INST_VALID, 1'b0);
        check_eq("retired", RETIRED, 32'(exp_retired));
        check_eq("halted", HALTED, halt);
        check_eq("pc", PC, exp_pc);
        check_eq("req_next", IMEM_REQ, !halt);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h00] = 8'h21;
        mem[8'h01] = 8'h35;
        last_inst = 8'h00;

        @(negedge CLK);
        apply_reset();

        // Straight-line fetch, a slow memory, load (with and without PC_EN), wrap, then halt.
        do_instr(0, 1'b1, 1'b0, 8'h00);
        do_instr(3, 1'b1, 1'b0, 8'h00);
        do_instr(0, 1'b0, 1'b1, 8'h40);
        do_instr(1, 1'b1, 1'b1, 8'hFF);
        do_instr(0, 1'b1, 1'b0, 8'h00);
        do_instr(0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            IMEM_ACK = 1'(i);
            IMEM_RDATA = 8'($urandom);
            @(negedge CLK);
            check_eq("halt_req", IMEM_REQ, 1'b0);
        end
        IMEM_ACK = 1'b0;
        check_eq("halt_pc", PC, exp_pc);
        check_eq("halt_inst", INST, last_inst);
        check_eq("halt_flag", HALTED, 1'b1);
        check_eq("halt_valid", INST_VALID, 1'b0);

        apply_reset();

        // Enough instructions to drive the retired counter into saturation.
        for (int i = 0; i < 18; i++) do_instr(0, 1'b1, 1'b0, 8'h00);

        // Reset landing mid-fetch, with an ACK arriving while it is held.
        do_instr(0, 1'b1, 1'b0, 8'h00);
        check_eq("mid_req_pre", IMEM_REQ, 1'b1);
        apply_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_eq("post_rst_req", IMEM_REQ, 1'b1);
        check_eq("post_rst_addr", IMEM_ADDR, 8'h00);
        check_eq("post_rst_inst", INST, 8'h00);
        check_eq("post_rst_valid", INST_VALID, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
